// File: rtl/muldiv_unit_pkg.sv
// Shared op/state encodings and latency defaults for the E-stage multiply/divide unit.
// The E-stage controller and the hazard unit import the same op constants.
package muldiv_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned MUL_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 10;
  // Latency counter width; both latencies must stay below 2**CNT_W.
  localparam int unsigned CNT_W = 8;

  function automatic logic is_muldiv(op_e op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div(op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// E-stage side of the multiply/divide unit: operands and op in, handshake and HI/LO out.
interface muldiv_unit_if;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  modport master (
    output op, a, b,
    input  start, busy, hi, lo, rdata
  );

  modport slave (
    input  op, a, b,
    output start, busy, hi, lo, rdata
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multiply/divide unit with HI/LO registers: result computed at issue, held in shadow
// registers and committed after a fixed latency window.
//
// state   | meaning
// ST_IDLE | accepts mult/div issue and mthi/mtlo writes
// ST_RUN  | latency window; counter runs down, commit on count 1
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      hi_n_q, hi_n_d, lo_n_q, lo_n_d;
  logic             wr_n_q, wr_n_d;
  op_e              op;

  logic [63:0]        prod_s, prod_u;
  logic               b_zero, div_ovf;
  logic [31:0]        div_b_s, div_b_u;
  logic signed [31:0] quo_s, rem_s;
  logic [31:0]        quo_u, rem_u;
  logic [31:0]        res_hi, res_lo;

  assign op = op_e'(bus.op);

  assign prod_s = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
  assign prod_u = {32'd0, bus.a} * {32'd0, bus.b};

  // Divisor forced to 1 for /0 (result discarded) and for MIN/-1, where a/1 is exactly
  // the architected answer and the divider never sees the overflowing case.
  assign b_zero  = (bus.b == 32'd0);
  assign div_ovf = (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);
  assign div_b_s = (b_zero || div_ovf) ? 32'd1 : bus.b;
  assign div_b_u = b_zero ? 32'd1 : bus.b;

  assign quo_s = $signed(bus.a) / $signed(div_b_s);
  assign rem_s = $signed(bus.a) % $signed(div_b_s);
  assign quo_u = bus.a / div_b_u;
  assign rem_u = bus.a % div_b_u;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    unique case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        res_hi = rem_s;
        res_lo = quo_s;
      end
      OP_DIVU: begin
        res_hi = rem_u;
        res_lo = quo_u;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_n_d  = hi_n_q;
    lo_n_d  = lo_n_q;
    wr_n_d  = wr_n_q;
    unique case (state_q)
      ST_IDLE: begin
        if (is_muldiv(op)) begin
          state_d = ST_RUN;
          cnt_d   = is_div(op) ? DIV_LOAD : MUL_LOAD;
          hi_n_d  = res_hi;
          lo_n_d  = res_lo;
          wr_n_d  = !(is_div(op) && b_zero);
        end else if (op == OP_MTHI) begin
          hi_d = bus.a;
        end else if (op == OP_MTLO) begin
          lo_d = bus.a;
        end
      end
      ST_RUN: begin
        // Ops arriving here are a hazard-unit fault and are deliberately ignored.
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          if (wr_n_q) begin
            hi_d = hi_n_q;
            lo_d = lo_n_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hi_n_q  <= 32'd0;
      lo_n_q  <= 32'd0;
      wr_n_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_n_q  <= hi_n_d;
      lo_n_q  <= lo_n_d;
      wr_n_q  <= wr_n_d;
    end
  end

  // start is masked by reset so the hazard unit sees no issue while the unit is held.
  assign bus.start = reset && (state_q == ST_IDLE) && is_muldiv(op);
  assign bus.busy  = (state_q == ST_RUN);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

  always_comb begin
    bus.rdata = 32'd0;
    if (op == OP_MFHI)      bus.rdata = hi_q;
    else if (op == OP_MFLO) bus.rdata = lo_q;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multiply/divide unit for the P6 five-stage pipeline. It sits in the E stage beside the ALU: it consumes the forwarded E-stage operands and the `muldivop` field decoded by the E-stage controller, holds the HI/LO architectural registers, and reports `start`/`busy` to the hazard unit, which stalls D-stage mult/div/mfhi/mflo/mthi/mtlo while the unit is occupied. Its `rdata` output is the E-stage result for mfhi/mflo and enters the E/M pipeline register like an ALU result.

## Interface
Parameters:
- `MUL_CYCLES`, 5: busy cycles for mult/multu.
- `DIV_CYCLES`, 10: busy cycles for div/divu.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `op`  in  4  muldivop of the instruction currently in E (encoding in package).
- `a`  in  32  forwarded rs value (FaluaE mux output).
- `b`  in  32  forwarded rt value (FalubE mux output).
- `start`  out  1  combinational; high while a mult/multu/div/divu is in E and the unit is idle.
- `busy`  out  1  registered; high during the operation's latency window.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.
- `rdata`  out  32  combinational: `hi` for MFHI, `lo` for MFLO, else 0.

## Operation
- States: IDLE, RUN. `busy` = (state == RUN).
- IDLE, op ∈ {MULT, MULTU, DIV, DIVU}: `start`=1. On the edge, latch the 64-bit result into shadow regs `hi_n`/`lo_n`, load counter with MUL_CYCLES or DIV_CYCLES, go to RUN.
- RUN: counter decrements every edge. On the edge where the counter is 1, commit `hi`←`hi_n`, `lo`←`lo_n`, go to IDLE.
- MULT: signed 32×32→64, {hi,lo}. MULTU: unsigned.
- DIV: lo = signed quotient truncated toward zero, hi = remainder with sign of dividend. DIVU: unsigned.
- DIV/DIVU with b==0: still runs DIV_CYCLES; HI/LO left unchanged at commit.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO in IDLE: write `hi`/`lo` from `a` on the edge, no busy.
- MFHI/MFLO: `rdata` selects current `hi`/`lo`; no state change.
- Any op other than NONE arriving in RUN is a hazard-unit fault: ignored, no state change; bench asserts it never occurs.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `start`=0 (op irrelevant in reset), counter=0, state IDLE.
- Cycle T: mult in E, `start`=1. Cycles T+1..T+MUL_CYCLES: `busy`=1. New HI/LO visible from cycle T+MUL_CYCLES+1, when `busy`=0. Same for div with DIV_CYCLES.
- Back-to-back: the next mult/div may be in E at T+N+1 and starts immediately.
- MTHI/MTLO in E at cycle T: visible on `hi`/`lo` at T+1; MFHI in E at T+1 reads the new value.
- Reset asserted mid-RUN: `busy` drops asynchronously, shadow result discarded, HI/LO = 0.
- No stall input: the hazard unit guarantees the E-stage op is NONE (bubble) while `busy`.

## Structure
- Package `muldiv_pkg`: op encoding NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8; state encoding; latency defaults.
- The E-stage controller and the hazard unit import the same op constants.
- Single module; no sub-module. Result computed at issue with the width-explicit signed/unsigned operators, then held in the shadow registers.

## Test plan
- mult a=0xFFFFFFFE (−2), b=3 -> start pulse at T, busy T+1..T+5, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles; hi/lo hold old values while busy.
- div a=−7 (0xFFFFFFF9), b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu same operands -> lo=0x7FFFFFFC, hi=1.
- div by zero with hi=0x11, lo=0x22 preloaded by mthi/mtlo -> busy 10 cycles, hi=0x11, lo=0x22 unchanged; mflo next cycle gives rdata=0x22.
- mthi a=0xDEADBEEF at T, mfhi at T+1 -> rdata=0xDEADBEEF; mult issued at T+2 starts with no extra stall.
- reset low at 3rd busy cycle of a div -> busy=0, hi=lo=0 immediately; after release, a mult completes normally in 5 busy cycles.
